// File: rtl/ysyx_scoreboard.sv
// ysyx_scoreboard: in-order register write scoreboard with speculative flush.
// Ports: clk, rst (sync, active-low); issue_* offer from decode; fwd_* from
// execute; wb_* retire; spec_resolve/flush from branch unit; rf_table busy
// bits, hazard, issue_ready, count/full/empty occupancy, sticky err.
module ysyx_scoreboard #(
  parameter int DEPTH = 4,
  parameter int NREG  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [3:0]               issue_rd,
  input  logic                     issue_wen,
  input  logic                     issue_spec,
  input  logic [3:0]               issue_rs1,
  input  logic [3:0]               issue_rs2,
  input  logic                     issue_use_rs1,
  input  logic                     issue_use_rs2,
  input  logic                     fwd_valid,
  input  logic [3:0]               fwd_rd,
  input  logic                     wb_valid,
  input  logic [3:0]               wb_rd,
  input  logic                     spec_resolve,
  input  logic                     flush,
  output logic [NREG-1:0]          rf_table,
  output logic                     hazard,
  output logic                     issue_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0]      v_q, v_d;
  logic [DEPTH-1:0]      sp_q, sp_d;
  logic [DEPTH-1:0][3:0] rd_q, rd_d;
  logic [AW:0]           head_q, head_d;
  logic [AW:0]           tail_q, tail_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [AW:0]           nspec;
  logic                  h1, h2;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign err   = err_q;

  always_comb begin
    rf_table = '0;
    for (int i = 0; i < DEPTH; i++)
      if (v_q[i]) rf_table[rd_q[i]] = 1'b1;
    rf_table[0] = 1'b0;
  end

  // A source still in flight is a hazard unless execute forwards it now.
  assign h1 = issue_use_rs1 & rf_table[issue_rs1]
            & !(fwd_valid & (fwd_rd == issue_rs1));
  assign h2 = issue_use_rs2 & rf_table[issue_rs2]
            & !(fwd_valid & (fwd_rd == issue_rs2));
  assign hazard      = issue_valid & (h1 | h2);
  assign issue_ready = !hazard & !full;

  // Order within a cycle: retire, then flush truncation, then push.
  always_comb begin
    v_d    = v_q;
    sp_d   = sp_q;
    rd_d   = rd_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    nspec  = '0;
    if (wb_valid && wb_rd != 4'd0) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        if (rd_q[head_q[AW-1:0]] != wb_rd) err_d = 1'b1;
        v_d[head_q[AW-1:0]] = 1'b0;
        head_d = head_q + 1'b1;
        cnt_d  = cnt_d - 1'b1;
      end
    end
    if (flush) begin
      // Speculative entries sit at the youngest end, so drop them off tail.
      for (int i = 0; i < DEPTH; i++) begin
        if (v_d[i] && sp_d[i]) begin
          v_d[i] = 1'b0;
          nspec  = nspec + 1'b1;
        end
      end
      tail_d = tail_d - nspec;
      cnt_d  = cnt_d - nspec;
    end else if (spec_resolve) begin
      sp_d = '0;
    end
    if (issue_valid && issue_ready && !flush
        && issue_wen && issue_rd != 4'd0) begin
      v_d[tail_d[AW-1:0]]  = 1'b1;
      rd_d[tail_d[AW-1:0]] = issue_rd;
      sp_d[tail_d[AW-1:0]] = issue_spec;
      tail_d = tail_d + 1'b1;
      cnt_d  = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= '0;
      sp_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      v_q    <= v_d;
      sp_q   <= sp_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_scoreboard.sv
// tb_ysyx_scoreboard: directed scenarios plus randomized traffic
// against a queue-based model of the scoreboard.
module tb_ysyx_scoreboard;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wen, issue_spec;
  logic [3:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_use_rs1, issue_use_rs2;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        spec_resolve, flush;
  logic [15:0] rf_table;
  logic        hazard, issue_ready, full, empty, err;
  logic [2:0]  count;

  typedef struct {
    logic [3:0] rd;
    logic       spec;
  } ent_t;

  ent_t q[$];
  bit   m_err;
  logic e_haz, e_rdy, o_haz, o_rdy;
  int   checks = 0;
  int   errors = 0;

  ysyx_scoreboard #(.DEPTH(DEPTH), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .issue_spec(issue_spec),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .spec_resolve(spec_resolve), .flush(flush),
    .rf_table(rf_table), .hazard(hazard), .issue_ready(issue_ready),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_rf();
    logic [15:0] r = '0;
    foreach (q[i]) r[q[i].rd] = 1'b1;
    r[0] = 1'b0;
    return r;
  endfunction

  function automatic bit model_has_spec();
    foreach (q[i]) if (q[i].spec) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    rst = 1'b1;
    issue_valid = 0; issue_wen = 0; issue_spec = 0;
    issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0;
    fwd_valid = 0; fwd_rd = 0;
    wb_valid = 0; wb_rd = 0;
    spec_resolve = 0; flush = 0;
  endtask

  // One clock: predict comb outputs, sample them mid-cycle, advance model.
  task automatic cyc();
    logic [15:0] r;
    r = model_rf();
    e_haz = issue_valid &&
      ((issue_use_rs1 && r[issue_rs1]
        && !(fwd_valid && fwd_rd == issue_rs1)) ||
       (issue_use_rs2 && r[issue_rs2]
        && !(fwd_valid && fwd_rd == issue_rs2)));
    e_rdy = !e_haz && (q.size() != DEPTH);
    @(negedge clk);
    o_haz = hazard;
    o_rdy = issue_ready;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_err = 0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        if (q.size() == 0) m_err = 1;
        else begin
          if (q[0].rd != wb_rd) m_err = 1;
          q.delete(0);
        end
      end
      if (flush) begin
        while (q.size() > 0 && q[q.size()-1].spec)
          q.delete(q.size()-1);
      end else if (spec_resolve) begin
        foreach (q[i]) q[i].spec = 1'b0;
      end
      if (issue_valid && e_rdy && !flush && issue_wen && issue_rd != 0)
        q.push_back('{rd: issue_rd, spec: issue_spec});
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc();
    idle();
  endtask

  task automatic issue(input logic [3:0] rd, input logic sp);
    idle();
    issue_valid = 1; issue_wen = 1; issue_rd = rd; issue_spec = sp;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rf_table !== 16'h0 || count !== 3'd0 || empty !== 1'b1
        || full !== 1'b0 || err !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: rf=%h cnt=%0d e=%b f=%b err=%b rdy=%b want 0 0 1 0 0 1",
               rf_table, count, empty, full, err, issue_ready);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    issue(4'd5, 1'b0);
    issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 4'd5;
    cyc();
    checks++;
    if (o_haz !== 1'b1 || o_rdy !== 1'b0) begin
      errors++;
      $display("FAIL hazard_nofwd: haz=%b rdy=%b want 1 0", o_haz, o_rdy);
    end
    issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 4'd5;
    fwd_valid = 1; fwd_rd = 4'd5;
    cyc();
    idle();
    checks++;
    if (o_haz !== 1'b0) begin
      errors++;
      $display("FAIL hazard_fwd: haz=%b want 0", o_haz);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) issue(4'(i), 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL full: full=%b cnt=%0d want 1 4", full, count);
    end
    issue_valid = 1; issue_wen = 1; issue_rd = 4'd8;
    wb_valid = 1; wb_rd = 4'd1;
    cyc();
    idle();
    checks++;
    if (o_rdy !== 1'b0 || count !== 3'd3) begin
      errors++;
      $display("FAIL full_wb: rdy=%b cnt=%0d want 0 3", o_rdy, count);
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_next: rdy=%b want 1", issue_ready);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue(4'd3, 1'b0);
    issue(4'd6, 1'b1);
    issue(4'd7, 1'b1);
    flush = 1;
    cyc();
    idle();
    checks++;
    if (count !== 3'd1 || rf_table !== 16'h0008) begin
      errors++;
      $display("FAIL flush: cnt=%0d rf=%h want 1 0008", count, rf_table);
    end
    wb_valid = 1; wb_rd = 4'd3;
    cyc();
    idle();
    checks++;
    if (empty !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL flush_wb: empty=%b err=%b want 1 0", empty, err);
    end
  endtask

  task automatic test_resolve();
    do_reset();
    issue(4'd3, 1'b0);
    issue(4'd6, 1'b1);
    issue(4'd7, 1'b1);
    spec_resolve = 1;
    cyc();
    idle();
    flush = 1;
    cyc();
    idle();
    checks++;
    if (count !== 3'd3 || rf_table !== 16'h00C8) begin
      errors++;
      $display("FAIL resolve: cnt=%0d rf=%h want 3 00c8", count, rf_table);
    end
  endtask

  task automatic test_err();
    do_reset();
    wb_valid = 1; wb_rd = 4'd9;
    cyc();
    idle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b want 1", err);
    end
    issue(4'd0, 1'b0);
    checks++;
    if (err !== 1'b1 || count !== 3'd0 || rf_table[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky_rd0: err=%b cnt=%0d rf0=%b want 1 0 0",
               err, count, rf_table[0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    issue(4'd2, 1'b0);
    issue(4'd4, 1'b0);
    rst = 0;
    issue_valid = 1; issue_wen = 1; issue_rd = 4'd6;
    wb_valid = 1; wb_rd = 4'd2;
    cyc();
    idle();
    checks++;
    if (rf_table !== 16'h0 || count !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rf=%h cnt=%0d err=%b want 0 0 0",
               rf_table, count, err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom % 60) != 0;
      issue_valid = ($urandom % 4) != 0;
      issue_wen = ($urandom % 5) != 0;
      issue_rd = 4'($urandom);
      issue_spec = model_has_spec() ? 1'b1 : (($urandom % 3) == 0);
      issue_rs1 = 4'($urandom);
      issue_rs2 = 4'($urandom);
      issue_use_rs1 = 1'($urandom);
      issue_use_rs2 = 1'($urandom);
      fwd_valid = 1'($urandom);
      fwd_rd = 4'($urandom);
      wb_valid = 1'($urandom);
      wb_rd = (q.size() > 0 && ($urandom % 16) != 0) ? q[0].rd : 4'($urandom);
      flush = ($urandom % 8) == 0;
      spec_resolve = ($urandom % 8) == 0;
      cyc();
      checks++;
      if (o_haz !== e_haz || o_rdy !== e_rdy) begin
        errors++;
        $display("FAIL rand_comb n=%0d: haz=%b rdy=%b want %b %b",
                 n, o_haz, o_rdy, e_haz, e_rdy);
      end
      checks++;
      if (count !== 3'(q.size()) || rf_table !== model_rf()
          || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)
          || err !== m_err) begin
        errors++;
        $display("FAIL rand_state n=%0d: cnt=%0d rf=%h f=%b e=%b err=%b want %0d %h %b %b %b",
                 n, count, rf_table, full, empty, err, q.size(), model_rf(),
                 q.size() == DEPTH, q.size() == 0, m_err);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_hazard();
    test_full();
    test_flush();
    test_resolve();
    test_err();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_scoreboard.md
YSYX_SCOREBOARD -- requirements
Module: ysyx_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning in-flight write FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter NREG, default 16, meaning architectural registers tracked (RV32E, 4-bit index).
REQ-003 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have ports issue_valid input 1, issue_rd input 4, issue_wen input 1, issue_spec input 1: decoded instruction offered by the decode stage, with its destination, rd-write flag and speculative tag.
REQ-006 SHALL have ports issue_rs1 input 4, issue_rs2 input 4, issue_use_rs1 input 1, issue_use_rs2 input 1: source operands of the offered instruction.
REQ-007 SHALL have ports fwd_valid input 1, fwd_rd input 4: execute-stage forwarding result valid this cycle for that register.
REQ-008 SHALL have ports wb_valid input 1, wb_rd input 4: register write retired this cycle.
REQ-009 SHALL have ports spec_resolve input 1 (branch confirmed, keep speculative writes) and flush input 1 (branch mispredicted, kill speculative writes).
REQ-010 SHALL have outputs rf_table output 16 (busy bit per register), hazard output 1, issue_ready output 1, count output $clog2(DEPTH)+1, full output 1, empty output 1, err output 1 (sticky).

Function
REQ-011 SHALL hold an in-order FIFO of DEPTH entries {valid, rd[3:0], spec}, with head/tail pointers one bit wider than the index for full/empty detection.
REQ-012 SHALL compute rf_table[r] combinationally = OR over valid entries with rd==r; rf_table[0] SHALL always be 0.
REQ-013 SHALL assert hazard = issue_valid & ((issue_use_rs1 & rf_table[issue_rs1] & !(fwd_valid & fwd_rd==issue_rs1)) | (same term for rs2)).
REQ-014 SHALL drive issue_ready = !hazard & !full, using registered full only; same-cycle wb SHALL NOT relieve full.
REQ-015 SHALL accept an issue when issue_valid & issue_ready & !flush; if issue_wen & issue_rd!=0, SHALL push {1, issue_rd, issue_spec} at tail; otherwise SHALL push nothing.
REQ-016 SHALL pop head on wb_valid & wb_rd!=0 when !empty; wb_rd != head rd SHALL set err and still pop.
REQ-017 SHALL ignore wb_valid when empty, or when wb_rd==0, and SHALL set err on wb_valid with wb_rd!=0 while empty.
REQ-018 SHALL clear spec on every valid entry on spec_resolve (one cycle, no pointer change).
REQ-019 SHALL on flush move tail back to the oldest spec entry (spec entries are contiguous at the youngest end) and invalidate all spec entries; with no spec entries, flush SHALL be a no-op.
REQ-020 Same-cycle precedence SHALL be: wb pop first, then flush truncation, then issue push (push suppressed by flush); spec_resolve with flush SHALL give flush priority.
REQ-021 Same-cycle push and pop SHALL leave count unchanged and the FIFO SHALL remain consistent at full and empty.
REQ-022 SHALL drive count as a register equal to the number of valid entries, full = (count==DEPTH), empty = (count==0).
REQ-023 SHALL wrap pointers modulo DEPTH with the extra bit toggling; no entry SHALL be lost or duplicated across wrap.
REQ-024 Latency: rf_table SHALL reflect a push or pop in the cycle after the accepting edge; hazard SHALL be zero-cycle combinational from issue and fwd inputs.

Reset
REQ-025 SHALL on rst==0 at posedge clear all entries, both pointers, count and err, giving rf_table=0, empty=1, full=0 and issue_ready=!hazard=1.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight entries regardless of wb, flush or issue in that cycle.

Verification
REQ-027 Issue rd=5 (wen); next cycle issue rs1=5 without fwd -> hazard=1, issue_ready=0; same with fwd_valid, fwd_rd=5 -> hazard=0.
REQ-028 Issue rd=1,2,3,4 back-to-back (DEPTH=4) -> full=1, count=4, issue_ready=0 on 5th offer even with wb_valid that cycle; next cycle ready=1.
REQ-029 Issue rd=3 non-spec, rd=6 spec, rd=7 spec; flush -> count=1, rf_table=0x0008; wb_rd=3 -> empty=1.
REQ-030 Same as REQ-029 but spec_resolve then flush -> count=3, rf_table=0x00C8 unchanged.
REQ-031 wb_valid with wb_rd=9 while empty -> err=1 and stays 1; issue with rd=0 -> count unchanged, rf_table[0]=0.
REQ-032 Fill 2 entries, assert rst=0 with simultaneous issue and wb -> next cycle rf_table=0, count=0, err=0.
